audio_cmd_arbiter: RTL and testbench

Round-robin arbiter that shares the audio controller's single command port (cs, rw, data[15:0]) among several requesters: sample streamer, sound-effect engine, volume/config writer. Sits between the requesters and the audio controller, replacing the direct point-to-point hookup. Issues one single-cycle command at a time, then enforces a programmable quiet gap so the controller can consume each word within its AC'97 frame.

---
 rtl/audio_pkg.sv | 6 +
 rtl/rr_pick.sv | 28 ++
 rtl/audio_cmd_arbiter.sv | 88 ++++++++
 tb/tb_audio_cmd_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared arbiter state encoding and audio command constants.
package audio_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} arb_state_e;
  localparam int AUDIO_DATA_W  = 16;
  localparam int AUDIO_GAP_48K = 2083;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority encoder; first set req bit at or above ptr (with wrap) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  logic [PW-1:0] k;
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = |req_i;
    k       = '0;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      k = PW'((int'(ptr_i) + i) % N);
      if (req_i[k]) begin
        idx_o    = k;
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/audio_cmd_arbiter.sv
// audio_cmd_arbiter: round-robin sharing of the audio controller command port,
// one single-cycle command at a time followed by a programmable quiet gap.
module audio_cmd_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = AUDIO_GAP_48K
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [NUM_REQ*AUDIO_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            cs,
  output logic                            rw,
  output logic [AUDIO_DATA_W-1:0]         data,
  output logic                            busy
);
  localparam int PW = $clog2(NUM_REQ);

  arb_state_e              state_q;
  logic [PW-1:0]           ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0]      gnt_q, win_gnt;
  logic                    any_req, cs_q, rw_q, busy_q;
  logic [AUDIO_DATA_W-1:0] data_q, data_d;
  logic [11:0]             cnt_q;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .valid_o(any_req)
  );

  assign data_d = req_data[int'(win_idx)*AUDIO_DATA_W +: AUDIO_DATA_W];
  assign ptr_d  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          state_q <= ISSUE;
          gnt_q   <= win_gnt;
          cs_q    <= 1'b1;
          rw_q    <= req_rw[win_idx];
          data_q  <= data_d;
          busy_q  <= 1'b1;
          ptr_q   <= ptr_d;
        end
        ISSUE: begin
          gnt_q <= '0;
          cs_q  <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state_q <= GAP;
            cnt_q   <= 12'(GAP_CYCLES - 1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        GAP: if (cnt_q == 12'd0) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 12'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign cs   = cs_q;
  assign rw   = rw_q;
  assign data = data_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_audio_cmd_arbiter.sv
// tb_audio_cmd_arbiter: directed and random stimulus checked against a
// timestamp-based scheduling model of the arbiter.
module tb_audio_cmd_arbiter;
  localparam int N = 4;
  localparam int G = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_rw = '0;
  logic [N*16-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            cs, rw, busy;
  logic [15:0]     data;

  audio_cmd_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_rw  (req_rw),
    .req_data(req_data),
    .gnt     (gnt),
    .cs      (cs),
    .rw      (rw),
    .data    (data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, e = 0;
  // Model: edge index of last issue, first edge at which a new request may be sampled.
  int m_ptr = 0, m_free = 0, m_issue = -100, m_win = 0;
  logic [15:0] m_data = '0;
  logic        m_rw = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_edge();
    int k;
    if (!rst) begin
      m_ptr = 0; m_free = 0; m_issue = -100; m_data = '0; m_rw = 1'b0;
    end else if (e >= m_free && req != '0) begin
      k = m_ptr;
      while (!req[k]) k = (k + 1) % N;
      m_win   = k;
      m_issue = e;
      m_free  = e + G + 2;
      m_ptr   = (k + 1) % N;
      m_data  = req_data[16*k +: 16];
      m_rw    = req_rw[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cs", cs, e == m_issue);
    check("gnt", gnt, (e == m_issue) ? (32'd1 << m_win) : 32'd0);
    check("data", data, m_data);
    check("rw", rw, m_rw);
    check("busy", busy, e >= m_issue && e <= m_issue + G);
    e++;
  endtask

  task automatic wait_cs(input int budget);
    int k = 0;
    do begin step(); k++; end while (!cs && k < budget);
    check("cs_timeout", cs, 1);
  endtask

  initial begin
    int t;
    logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    // Reset held with all requesting
    req = 4'b1111;
    req_data = 64'hDDDD_CCCC_BBBB_AAAA;
    req_rw = 4'b1010;
    repeat (3) step();
    rst = 1'b1;
    wait_cs(3);
    check("first_gnt", gnt, 4'b0001);
    check("first_data", data, 16'hAAAA);
    // Fairness with continuous requests
    foreach (rr_exp[i]) begin
      t = e;
      wait_cs(10);
      check("rr_gnt", gnt, rr_exp[i]);
      check("rr_spacing", e - t, G + 2);
    end
    // Single requester
    req = 4'b0100;
    req_data[47:32] = 16'h1234;
    req_rw = 4'b0100;
    wait_cs(10);
    check("single_gnt", gnt, 4'b0100);
    check("single_data", data, 16'h1234);
    check("single_rw", rw, 1'b1);
    t = e;
    wait_cs(10);
    check("single_spacing", e - t, G + 2);
    // Skip and wrap from pointer 3
    req = 4'b0011;
    wait_cs(10);
    check("wrap_gnt0", gnt, 4'b0001);
    wait_cs(10);
    check("wrap_gnt1", gnt, 4'b0010);
    // Requests only during the gap are ignored
    req = '0;
    step();
    req = 4'b0010;
    repeat (3) step();
    req = '0;
    repeat (6) step();
    check("gap_idle", busy, 1'b0);
    // Withdrawal after latching still issues
    req = 4'b0010;
    req_data[31:16] = 16'h5A5A;
    step();
    req = '0;
    check("wd_gnt", gnt, 4'b0010);
    check("wd_data", data, 16'h5A5A);
    repeat (6) step();
    // Reset in GAP with counter at 1
    req = 4'b0001;
    wait_cs(10);
    req = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_cs", cs, 1'b0);
    check("rst_data", data, 16'h0000);
    step();
    rst = 1'b1;
    repeat (8) step();
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 2) == 0) req_rw = N'($urandom);
      if ($urandom_range(0, 1) == 0) req_data = {$urandom, $urandom};
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
